stage5_integration: RTL and testbench
=====================================

STAGE5_INTEGRATION -- requirements
Module: stage5_integration

Interface
REQ-001 SHALL have ports, all 1-bit unless stated: CLK in, clock; RST_N in, asynchronous active-low reset; one clock, reset async active-low.
REQ-002 SHALL have inputs SignExtOut, ZeroExtOut, ResOut, each 16 bits: sign-extended immediate, zero-extended immediate, ALU result.
REQ-003 SHALL have inputs MSPWrite, MSPPop, RSPWrite, RSPPop: main/return stack-pointer update enable and direction.
REQ-004 SHALL have inputs PCWrite, PCSource, PCAdd: PC update enable, next-PC source, offset select.
REQ-005 SHALL have inputs ValAWrite, ValBWrite, IRWrite: operand and instruction register load enables.
REQ-006 SHALL have inputs MemRead1, MemRead2, MemWrite1, MemWrite2 (per-port memory strobes), MemDst1 [1:0], MemDst2 [1:0] (address selects), and MemData [2:0] (write-data select).
REQ-007 SHALL have outputs ValAOut, ValBOut, IROut, PCOut, MSPOut, RSPOut, each 16 bits: register contents.

Function
REQ-008 All state SHALL update on rising CLK only; all selects SHALL use values present before the edge.
REQ-009 PC: PCWrite=0 holds. PCWrite=1 with PCSource=0, PCAdd=0 gives PC+1; with PCSource=0, PCAdd=1 gives PC+SignExtOut; with PCSource=1 gives ResOut. Arithmetic is mod 2^16.
REQ-010 MSP: MSPWrite=0 holds; MSPWrite=1, MSPPop=0 gives MSP+1; MSPWrite=1, MSPPop=1 gives MSP-1. Wraps mod 2^16 (0-1=FFFF).
REQ-011 RSP SHALL behave identically to MSP, using RSPWrite/RSPPop.
REQ-012 Memory: 256 x 16-bit words, two ports, address = low 8 bits of the selected source.
REQ-013 Port-1 address (MemDst1): 00 PC, 01 ValA, 10 ValB, 11 ResOut.
REQ-014 Port-2 address (MemDst2): 00 MSP, 01 RSP, 10 ValA, 11 ResOut.
REQ-015 Reads are synchronous: MemReadN=1 captures mem[addrN] into read register N at the edge; otherwise read register N holds. Latency is 1 cycle to the read register, then 1 more cycle to IR/ValA/ValB.
REQ-016 Write data (MemData): 000 ValA, 001 ValB, 010 PC, 011 ResOut, 100 SignExtOut, 101 ZeroExtOut, 110 MSP, 111 RSP. Both ports write this same value.
REQ-017 MemWriteN=1 writes the value at addrN at the edge. If both ports write the same address, port 1 wins. Read-during-write on the same address returns the old data.
REQ-018 Loads: IRWrite=1 loads IR from read register 1; ValBWrite=1 loads ValB from read register 1; ValAWrite=1 loads ValA from read register 2. Otherwise each holds.
REQ-019 Memory initial content SHALL be mem[i] = i mod 10, for i = 0..255, at power-up/simulation start.

Reset
REQ-020 RST_N=0 SHALL immediately clear PC, MSP, RSP, IR, ValA, ValB and both read registers to 0000. Memory contents SHALL be unaffected.
REQ-021 Reset asserted mid-sequence SHALL discard pending reads. Operation resumes on the first edge after RST_N rises.

Structure
REQ-022 A shared package SHALL hold: data width 16, memory depth 256 / address width 8, and the MemDst1, MemDst2 and MemData encodings as named constants.
REQ-023 The memory SHALL be one sub-module, dual_port_ram, containing the two sync-read ports, the write ports, the init and the port-1 write priority. Muxes and registers stay in the top module.

Verification
REQ-024 Reset, then 55 cycles of MSPWrite=1, MSPPop=0 -> MSPOut=0037. PC, RSP, IR, ValA and ValB remain 0000.
REQ-025 Fetch cycle: MSPWrite=1, MSPPop=1, PCWrite=1, MemRead1=1, MemRead2=1, MemDst1=MemDst2=00; next cycle IRWrite=1, ValAWrite=1. Repeat 50 times from MSP=0037, PC=0 -> each iteration IROut = oldPC mod 10, ValAOut = oldMSP mod 10, ValBOut unchanged. PC and MSP each move by 1 per iteration.
REQ-026 MSP=0 with MSPWrite=1, MSPPop=1 -> MSPOut=FFFF. PC=FFFF with PC+1 -> 0000.
REQ-027 PCSource=1, ResOut=1234 -> PCOut=1234. PCAdd=1, SignExtOut=FFFE from PC=0010 -> 000E.
REQ-028 ValA=0005, MemData=011, ResOut=ABCD, MemDst1=01, MemWrite1=1; then read port 2 with MemDst2=10 and ValAWrite=1 -> ValAOut=ABCD. Simultaneous port-1/port-2 writes to the same address -> the port-1 data is stored.
REQ-029 RST_N pulsed low between the read and load cycles -> all registers read 0000 and the following load yields 0000.

Source files
------------

// File: rtl/stage5_integration_pkg.sv
// Shared widths, memory geometry and select encodings for the stage-5 datapath.
package stage5_integration_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  // Whole-memory image; packed so it can be produced by a function at elaboration.
  typedef logic [MEM_DEPTH-1:0][DATA_W-1:0] memImage_t;

  // Port-1 address source (MemDst1)
  localparam logic [1:0] DST1_PC   = 2'b00;
  localparam logic [1:0] DST1_VALA = 2'b01;
  localparam logic [1:0] DST1_VALB = 2'b10;
  localparam logic [1:0] DST1_RES  = 2'b11;

  // Port-2 address source (MemDst2)
  localparam logic [1:0] DST2_MSP  = 2'b00;
  localparam logic [1:0] DST2_RSP  = 2'b01;
  localparam logic [1:0] DST2_VALA = 2'b10;
  localparam logic [1:0] DST2_RES  = 2'b11;

  // Write-data source (MemData), shared by both ports
  localparam logic [2:0] MDATA_VALA = 3'b000;
  localparam logic [2:0] MDATA_VALB = 3'b001;
  localparam logic [2:0] MDATA_PC   = 3'b010;
  localparam logic [2:0] MDATA_RES  = 3'b011;
  localparam logic [2:0] MDATA_SEXT = 3'b100;
  localparam logic [2:0] MDATA_ZEXT = 3'b101;
  localparam logic [2:0] MDATA_MSP  = 3'b110;
  localparam logic [2:0] MDATA_RSP  = 3'b111;

  // Power-up memory image: word i holds i mod 10.
  function automatic memImage_t memInitImage();
    memImage_t img;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      img[i] = word_t'(i % 10);
    end
    return img;
  endfunction

endpackage

// File: rtl/stage5_integration_ram.sv
// Two-port 256x16 memory: shared write data, port 1 wins on a same-address
// write collision, synchronous reads that return the pre-write (old) data.
module dual_port_ram
  import stage5_integration_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  addr_t addr1,
  input  addr_t addr2,
  input  word_t wrData,
  input  logic  rdEn1,
  input  logic  rdEn2,
  input  logic  wrEn1,
  input  logic  wrEn2,
  output word_t rdData1,
  output word_t rdData2
);

  // Contents survive reset; only the power-up image initialises them.
  memImage_t memArray = memInitImage();

  // Port 2 is written first so a port-1 write to the same word overrides it.
  always_ff @(posedge CLK) begin
    if (wrEn2) memArray[addr2] <= wrData;
    if (wrEn1) memArray[addr1] <= wrData;
  end

  // Read registers: capture on enable, hold otherwise; reset drops pending reads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdData1 <= '0;
      rdData2 <= '0;
    end else begin
      if (rdEn1) rdData1 <= memArray[addr1];
      if (rdEn2) rdData2 <= memArray[addr2];
    end
  end

endmodule

// File: rtl/stage5_integration.sv
// Stage-5 datapath: PC, two stack pointers, IR/ValA/ValB and the memory
// address/data selection around the dual-port RAM.
module stage5_integration
  import stage5_integration_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] SignExtOut,
  input  logic [DATA_W-1:0] ZeroExtOut,
  input  logic [DATA_W-1:0] ResOut,
  input  logic              MSPWrite,
  input  logic              MSPPop,
  input  logic              RSPWrite,
  input  logic              RSPPop,
  input  logic              PCWrite,
  input  logic              PCSource,
  input  logic              PCAdd,
  input  logic              ValAWrite,
  input  logic              ValBWrite,
  input  logic              IRWrite,
  input  logic              MemRead1,
  input  logic              MemRead2,
  input  logic              MemWrite1,
  input  logic              MemWrite2,
  input  logic [1:0]        MemDst1,
  input  logic [1:0]        MemDst2,
  input  logic [2:0]        MemData,
  output logic [DATA_W-1:0] ValAOut,
  output logic [DATA_W-1:0] ValBOut,
  output logic [DATA_W-1:0] IROut,
  output logic [DATA_W-1:0] PCOut,
  output logic [DATA_W-1:0] MSPOut,
  output logic [DATA_W-1:0] RSPOut
);

  word_t pcReg, mspReg, rspReg, irReg, valAReg, valBReg;
  word_t pcNext, mspNext, rspNext;
  word_t addrSel1, addrSel2, wrData;
  word_t rdData1, rdData2;

  // Next-state values for the PC and both stack pointers (all mod 2^16).
  always_comb begin
    pcNext  = pcReg + word_t'(1);
    if (PCSource)   pcNext = ResOut;
    else if (PCAdd) pcNext = pcReg + SignExtOut;
    mspNext = MSPPop ? (mspReg - word_t'(1)) : (mspReg + word_t'(1));
    rspNext = RSPPop ? (rspReg - word_t'(1)) : (rspReg + word_t'(1));
  end

  // Memory address sources for both ports and the shared write data.
  always_comb begin
    addrSel1 = pcReg;
    addrSel2 = mspReg;
    wrData   = valAReg;
    case (MemDst1)
      DST1_PC:   addrSel1 = pcReg;
      DST1_VALA: addrSel1 = valAReg;
      DST1_VALB: addrSel1 = valBReg;
      default:   addrSel1 = ResOut;
    endcase
    case (MemDst2)
      DST2_MSP:  addrSel2 = mspReg;
      DST2_RSP:  addrSel2 = rspReg;
      DST2_VALA: addrSel2 = valAReg;
      default:   addrSel2 = ResOut;
    endcase
    case (MemData)
      MDATA_VALA: wrData = valAReg;
      MDATA_VALB: wrData = valBReg;
      MDATA_PC:   wrData = pcReg;
      MDATA_RES:  wrData = ResOut;
      MDATA_SEXT: wrData = SignExtOut;
      MDATA_ZEXT: wrData = ZeroExtOut;
      MDATA_MSP:  wrData = mspReg;
      default:    wrData = rspReg;
    endcase
  end

  dual_port_ram uRam (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .addr1   (addrSel1[ADDR_W-1:0]),
    .addr2   (addrSel2[ADDR_W-1:0]),
    .wrData  (wrData),
    .rdEn1   (MemRead1),
    .rdEn2   (MemRead2),
    .wrEn1   (MemWrite1),
    .wrEn2   (MemWrite2),
    .rdData1 (rdData1),
    .rdData2 (rdData2)
  );

  // Architectural registers: each loads only on its enable, cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcReg   <= '0;
      mspReg  <= '0;
      rspReg  <= '0;
      irReg   <= '0;
      valAReg <= '0;
      valBReg <= '0;
    end else begin
      if (PCWrite)   pcReg   <= pcNext;
      if (MSPWrite)  mspReg  <= mspNext;
      if (RSPWrite)  rspReg  <= rspNext;
      if (IRWrite)   irReg   <= rdData1;
      if (ValBWrite) valBReg <= rdData1;
      if (ValAWrite) valAReg <= rdData2;
    end
  end

  assign PCOut   = pcReg;
  assign MSPOut  = mspReg;
  assign RSPOut  = rspReg;
  assign IROut   = irReg;
  assign ValAOut = valAReg;
  assign ValBOut = valBReg;

endmodule

// File: tb/tb_stage5_integration.sv
// Directed bench for stage5_integration: expectations are queued when the
// stimulus is driven and popped against the DUT outputs once they settle.
module tb_stage5_integration;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] SignExtOut, ZeroExtOut, ResOut;
  logic        MSPWrite, MSPPop, RSPWrite, RSPPop;
  logic        PCWrite, PCSource, PCAdd;
  logic        ValAWrite, ValBWrite, IRWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2;
  logic [2:0]  MemData;
  logic [15:0] ValAOut, ValBOut, IROut, PCOut, MSPOut, RSPOut;

  int checkCount = 0;
  int passCount  = 0;
  string       tagQ[$];
  logic [15:0] expQ[$];

  always #5 CLK = ~CLK;

  stage5_integration dut (
    .CLK(CLK), .RST_N(RST_N),
    .SignExtOut(SignExtOut), .ZeroExtOut(ZeroExtOut), .ResOut(ResOut),
    .MSPWrite(MSPWrite), .MSPPop(MSPPop), .RSPWrite(RSPWrite), .RSPPop(RSPPop),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2),
    .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .ValAOut(ValAOut), .ValBOut(ValBOut), .IROut(IROut),
    .PCOut(PCOut), .MSPOut(MSPOut), .RSPOut(RSPOut)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearCtl();
    MSPWrite = 0; MSPPop = 0; RSPWrite = 0; RSPPop = 0;
    PCWrite = 0; PCSource = 0; PCAdd = 0;
    ValAWrite = 0; ValBWrite = 0; IRWrite = 0;
    MemRead1 = 0; MemRead2 = 0; MemWrite1 = 0; MemWrite2 = 0;
    MemDst1 = 2'b00; MemDst2 = 2'b00; MemData = 3'b000;
  endtask

  task automatic pushExp(input string tag, input logic [15:0] value);
    tagQ.push_back(tag);
    expQ.push_back(value);
  endtask

  // Pop the oldest expectation and compare it with the observed output.
  task automatic checkFront(input logic [15:0] obs);
    string       tag;
    logic [15:0] expv;
    checkCount++;
    if (expQ.size() == 0) begin
      $error("FAIL scoreboard: observed %h with no expected entry queued", obs);
    end else begin
      tag  = tagQ.pop_front();
      expv = expQ.pop_front();
      assert (obs === expv) passCount++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      $display("check %-14s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Write via port 1 at a ResOut address with the given data source, read it
  // back through port 1 and load it into IR.
  task automatic roundTrip(input string tag, input logic [2:0] sel,
                           input logic [15:0] addr, input logic [15:0] expv);
    MemData = sel; ResOut = addr; MemDst1 = 2'b11; MemWrite1 = 1; tick(); clearCtl();
    ResOut = addr; MemDst1 = 2'b11; MemRead1 = 1; tick(); clearCtl();
    IRWrite = 1; tick(); clearCtl();
    pushExp(tag, expv);
    checkFront(IROut);
  endtask

  initial begin
    logic [15:0] pcModel, mspModel;
    RST_N = 0; SignExtOut = '0; ZeroExtOut = '0; ResOut = '0;
    clearCtl();

    // Reset state
    #12;
    pushExp("rst_pc", 16'h0); pushExp("rst_msp", 16'h0); pushExp("rst_rsp", 16'h0);
    pushExp("rst_ir", 16'h0); pushExp("rst_vala", 16'h0); pushExp("rst_valb", 16'h0);
    checkFront(PCOut); checkFront(MSPOut); checkFront(RSPOut);
    checkFront(IROut); checkFront(ValAOut); checkFront(ValBOut);
    tick();
    RST_N = 1;

    // 55 pushes on the main stack
    MSPWrite = 1; MSPPop = 0;
    for (int i = 0; i < 55; i++) tick();
    clearCtl();
    pushExp("push55_msp", 16'h0037); pushExp("push55_pc", 16'h0);
    pushExp("push55_rsp", 16'h0); pushExp("push55_ir", 16'h0);
    pushExp("push55_vala", 16'h0); pushExp("push55_valb", 16'h0);
    checkFront(MSPOut); checkFront(PCOut); checkFront(RSPOut);
    checkFront(IROut); checkFront(ValAOut); checkFront(ValBOut);

    // 50 fetch iterations
    pcModel = 16'h0000;
    mspModel = 16'h0037;
    for (int i = 0; i < 50; i++) begin
      MSPWrite = 1; MSPPop = 1; PCWrite = 1; MemRead1 = 1; MemRead2 = 1;
      MemDst1 = 2'b00; MemDst2 = 2'b00;
      pushExp("fetch_ir", 16'((pcModel & 16'h00FF) % 10));
      pushExp("fetch_vala", 16'((mspModel & 16'h00FF) % 10));
      pcModel = pcModel + 16'd1;
      mspModel = mspModel - 16'd1;
      pushExp("fetch_valb", 16'h0);
      pushExp("fetch_pc", pcModel);
      pushExp("fetch_msp", mspModel);
      tick(); clearCtl();
      IRWrite = 1; ValAWrite = 1;
      tick(); clearCtl();
      checkFront(IROut); checkFront(ValAOut); checkFront(ValBOut);
      checkFront(PCOut); checkFront(MSPOut);
    end

    // MSP underflow wrap (MSP is 5 here)
    MSPWrite = 1; MSPPop = 1;
    for (int i = 0; i < 5; i++) tick();
    pushExp("msp_zero", 16'h0000); checkFront(MSPOut);
    tick(); clearCtl();
    pushExp("msp_wrap", 16'hFFFF); checkFront(MSPOut);

    // Return stack: up 3, down 1
    RSPWrite = 1; RSPPop = 0;
    for (int i = 0; i < 3; i++) tick();
    RSPPop = 1; tick(); clearCtl();
    pushExp("rsp_updown", 16'h0002); checkFront(RSPOut);

    // PC sources and wrap
    PCWrite = 1; PCSource = 1; ResOut = 16'hFFFF; tick();
    pushExp("pc_res_ffff", 16'hFFFF); checkFront(PCOut);
    PCSource = 0; PCAdd = 0; tick();
    pushExp("pc_inc_wrap", 16'h0000); checkFront(PCOut);
    PCSource = 1; ResOut = 16'h1234; tick();
    pushExp("pc_res_1234", 16'h1234); checkFront(PCOut);
    ResOut = 16'h0010; tick();
    PCSource = 0; PCAdd = 1; SignExtOut = 16'hFFFE; tick();
    pushExp("pc_add_neg", 16'h000E); checkFront(PCOut);
    PCWrite = 0; PCSource = 1; ResOut = 16'h7777; tick();
    pushExp("pc_hold", 16'h000E); checkFront(PCOut);
    PCWrite = 1; PCSource = 0; PCAdd = 1; SignExtOut = 16'h0005; tick(); clearCtl();
    pushExp("pc_add_pos", 16'h0013); checkFront(PCOut);

    // ValA = mem[5] = 5, write ABCD at ValA, read it back through port 2
    MemRead2 = 1; MemDst2 = 2'b11; ResOut = 16'h0005; tick(); clearCtl();
    ValAWrite = 1; tick(); clearCtl();
    pushExp("vala_init5", 16'h0005); checkFront(ValAOut);
    MemData = 3'b011; ResOut = 16'hABCD; MemDst1 = 2'b01; MemWrite1 = 1; tick(); clearCtl();
    MemRead2 = 1; MemDst2 = 2'b10; tick(); clearCtl();
    ValAWrite = 1; tick(); clearCtl();
    pushExp("vala_abcd", 16'hABCD); checkFront(ValAOut);

    // Read-during-write on port 1 returns old data, then the new data
    ResOut = 16'h0021; MemDst1 = 2'b11; MemData = 3'b100; SignExtOut = 16'h5A5A;
    MemWrite1 = 1; MemRead1 = 1; tick(); clearCtl();
    IRWrite = 1; tick(); clearCtl();
    pushExp("rdw_old", 16'h0003); checkFront(IROut);
    ResOut = 16'h0021; MemDst1 = 2'b11; MemRead1 = 1; tick(); clearCtl();
    IRWrite = 1; ValBWrite = 1; tick(); clearCtl();
    pushExp("rdw_new_ir", 16'h5A5A); pushExp("rdw_new_valb", 16'h5A5A);
    checkFront(IROut); checkFront(ValBOut);

    // Port-2 write at MSP (FFFF -> address FF), read back with upper bits ignored
    MemData = 3'b110; MemDst2 = 2'b00; MemWrite2 = 1; tick(); clearCtl();
    ResOut = 16'h01FF; MemDst1 = 2'b11; MemRead1 = 1; tick(); clearCtl();
    IRWrite = 1; tick(); clearCtl();
    pushExp("p2_write", 16'hFFFF); checkFront(IROut);

    // Both ports write the same word
    ResOut = 16'h0040; MemDst1 = 2'b11; MemDst2 = 2'b11; MemData = 3'b101;
    ZeroExtOut = 16'h00C3; MemWrite1 = 1; MemWrite2 = 1; tick(); clearCtl();
    ResOut = 16'h0040; MemDst1 = 2'b11; MemDst2 = 2'b11; MemRead1 = 1; MemRead2 = 1;
    tick(); clearCtl();
    IRWrite = 1; ValAWrite = 1; tick(); clearCtl();
    pushExp("collide_ir", 16'h00C3); pushExp("collide_vala", 16'h00C3);
    checkFront(IROut); checkFront(ValAOut);

    // Port-1 address from ValB (5A5A -> mem[90] = 0), port-2 from RSP (2 -> 2)
    MemDst1 = 2'b10; MemRead1 = 1; MemDst2 = 2'b01; MemRead2 = 1; tick(); clearCtl();
    ValBWrite = 1; ValAWrite = 1; tick(); clearCtl();
    pushExp("dst1_valb", 16'h0000); pushExp("dst2_rsp", 16'h0002);
    checkFront(ValBOut); checkFront(ValAOut);

    // Every write-data source (ValA=2, ValB=0, PC=13, MSP=FFFF, RSP=2)
    SignExtOut = 16'h1357; ZeroExtOut = 16'h2468;
    roundTrip("mdata_vala", 3'b000, 16'h0060, 16'h0002);
    roundTrip("mdata_valb", 3'b001, 16'h0061, 16'h0000);
    roundTrip("mdata_pc",   3'b010, 16'h0062, 16'h0013);
    roundTrip("mdata_res",  3'b011, 16'h0063, 16'h0063);
    roundTrip("mdata_sext", 3'b100, 16'h0064, 16'h1357);
    roundTrip("mdata_zext", 3'b101, 16'h0065, 16'h2468);
    roundTrip("mdata_msp",  3'b110, 16'h0066, 16'hFFFF);
    roundTrip("mdata_rsp",  3'b111, 16'h0067, 16'h0002);

    // Reset between a read and its load discards the pending read
    PCWrite = 1; PCSource = 1; ResOut = 16'h0007; tick(); clearCtl();
    MemRead1 = 1; MemDst1 = 2'b00; MemRead2 = 1; MemDst2 = 2'b10; tick(); clearCtl();
    RST_N = 0;
    #2;
    pushExp("mid_rst_pc", 16'h0); pushExp("mid_rst_msp", 16'h0);
    pushExp("mid_rst_rsp", 16'h0); pushExp("mid_rst_ir", 16'h0);
    pushExp("mid_rst_vala", 16'h0); pushExp("mid_rst_valb", 16'h0);
    checkFront(PCOut); checkFront(MSPOut); checkFront(RSPOut);
    checkFront(IROut); checkFront(ValAOut); checkFront(ValBOut);
    tick();
    RST_N = 1;
    IRWrite = 1; ValAWrite = 1; ValBWrite = 1; tick(); clearCtl();
    pushExp("post_rst_ir", 16'h0); pushExp("post_rst_vala", 16'h0);
    pushExp("post_rst_valb", 16'h0);
    checkFront(IROut); checkFront(ValAOut); checkFront(ValBOut);

    // Memory contents survive reset
    ResOut = 16'h0005; MemDst1 = 2'b11; MemRead1 = 1; tick(); clearCtl();
    IRWrite = 1; tick(); clearCtl();
    pushExp("mem_keeps", 16'hABCD); checkFront(IROut);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
